// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - request/acknowledge instruction-memory bus (MOV/MOC style)
interface mips_fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_data
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS fetch stage: PC sequencer, single-outstanding memory request, instruction buffer
module mips_fetch_unit #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 4,
   parameter int                PC_STEP   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   mips_fetch_unit_if.master          mem,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic [DATA_W-1:0]          ir,
   output logic [ADDR_W-1:0]          ir_pc,
   output logic                       ir_valid,
   input  logic                       ir_ready,
   output logic [ADDR_W-1:0]          fetch_pc,
   output logic [$clog2(BUF_DEPTH):0] buf_count
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;

   logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
   logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];

   logic              push;
   logic              pop;
   logic              issue;
   logic [CNT_W-1:0]  cnt_after_pop;
   logic [PTR_W-1:0]  rd_next;

   // A redirect kills both the returning word and any pop in the same cycle.
   assign push          = (state_q == S_REQ) && mem.mem_ack && !redirect;
   assign pop           = (count_q != '0) && ir_ready && !redirect;
   assign cnt_after_pop = count_q - CNT_W'(pop);
   assign rd_next       = rd_ptr_q + PTR_W'(1);
   assign issue         = (state_q == S_IDLE) && (state_d == S_REQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!redirect && (cnt_after_pop < CNT_W'(BUF_DEPTH))) state_d = S_REQ;
         S_REQ: begin
            if (mem.mem_ack)   state_d = S_IDLE;
            else if (redirect) state_d = S_DROP;
         end
         S_DROP: if (mem.mem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req  = (state_q == S_REQ) || (state_q == S_DROP);
      mem.mem_addr = mem_addr_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q - CNT_W'(pop) + CNT_W'(push);
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;

      if (issue)
         mem_addr_d = fetch_pc_q;
      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)
         rd_ptr_d = rd_next;

      // Head register tracks whichever entry will sit at the front next cycle.
      if (push && (cnt_after_pop == '0)) begin
         ir_d    = mem.mem_data;
         ir_pc_d = mem_addr_q;
      end else if (pop && (cnt_after_pop != '0)) begin
         ir_d    = buf_data_q[rd_next];
         ir_pc_d = buf_pc_q[rd_next];
      end

      if (push)
         fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);

      if (redirect) begin
         fetch_pc_d = redirect_pc & ~ADDR_W'(3);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_q       <= '0;
         ir_pc_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= mem.mem_data;
         buf_pc_q[wr_ptr_q]   <= mem_addr_q;
      end
   end

   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = (count_q != '0);
   assign fetch_pc  = fetch_pc_q;
   assign buf_count = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - randomized self-checking bench for mips_fetch_unit against a queue-based reference model
module tb_mips_fetch_unit;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] ir, ir_pc, fetch_pc;
   logic        ir_valid, ir_ready;
   logic [2:0]  buf_count;

   mips_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   mips_fetch_unit #(
      .ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH), .PC_STEP(4)
   ) dut (
      .clk(clk), .reset(reset), .mem(mem_if),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .fetch_pc(fetch_pc), .buf_count(buf_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   int n_checks = 0;
   int n_errors = 0;

   ent_t        q[$];
   bit          out_v, out_drop;
   logic [31:0] out_addr, exp_fetch_pc;
   int          age, cur_lat, lat_cfg;
   int          cyc;
   int          first_req_cyc, first_valid_cyc;
   bit          prev_req;
   logic [31:0] rise_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   task automatic model_reset();
      q.delete();
      out_v        = 1'b0;
      out_drop     = 1'b0;
      out_addr     = RST_PC;
      exp_fetch_pc = RST_PC;
      age          = 0;
      prev_req     = 1'b0;
   endtask

   task automatic compare();
      chk("buf_count", buf_count, q.size());
      chk("ir_valid", ir_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("ir", ir, q[0].data);
         chk("ir_pc", ir_pc, q[0].pc);
      end
      chk("fetch_pc", fetch_pc, exp_fetch_pc);
      chk("mem_req", mem_if.mem_req, out_v);
      if (out_v) chk("mem_addr", mem_if.mem_addr, out_addr);
      if (mem_if.mem_req && !prev_req) begin
         rise_log.push_back(mem_if.mem_addr);
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (ir_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_req = mem_if.mem_req;
   endtask

   // Called at a falling edge: plays memory, drives inputs, advances the model over the next rising edge.
   task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
      bit   ack;
      bit   pop;
      ent_t e;
      ack = 1'b0;
      if (mem_if.mem_req) begin
         if (age == 0) cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
         ack = (age >= cur_lat);
         age = ack ? 0 : age + 1;
      end else begin
         age = 0;
      end
      mem_if.mem_ack  = ack;
      mem_if.mem_data = ack ? memword(mem_if.mem_addr) : $urandom;
      ir_ready        = rdy;
      redirect        = redir;
      redirect_pc     = rpc;

      pop = (q.size() != 0) && rdy && !redir;
      if (pop) void'(q.pop_front());
      if (out_v) begin
         if (ack) begin
            if (!out_drop && !redir) begin
               e.pc   = out_addr;
               e.data = memword(out_addr);
               q.push_back(e);
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            out_v    = 1'b0;
            out_drop = 1'b0;
         end else if (redir) begin
            out_drop = 1'b1;
         end
      end else if (!redir && q.size() < DEPTH) begin
         out_v    = 1'b1;
         out_addr = exp_fetch_pc;
         out_drop = 1'b0;
      end
      if (redir) begin
         q.delete();
         exp_fetch_pc = rpc & ~32'h3;
      end

      @(negedge clk);
      cyc++;
      compare();
   endtask

   int n0;

   initial begin
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_pc     = '0;
      ir_ready        = 1'b0;
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_data = '0;
      cyc             = 0;
      first_req_cyc   = -1;
      first_valid_cyc = -1;
      lat_cfg         = 1;
      cur_lat         = 0;
      model_reset();

      @(negedge clk);
      chk("rst_mem_req", mem_if.mem_req, 1'b0);
      chk("rst_mem_addr", mem_if.mem_addr, RST_PC);
      chk("rst_fetch_pc", fetch_pc, RST_PC);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ir_pc", ir_pc, 32'h0);
      chk("rst_buf_count", buf_count, 3'd0);
      chk("rst_ir_valid", ir_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Sequential fetch with one-wait memory
      for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, '0);
      chk("first_ir_latency", first_valid_cyc - first_req_cyc, 2);
      chk("seq_addr1", rise_log[1], 32'h4);
      chk("seq_addr2", rise_log[2], 32'h8);

      // Stalled consumer fills the buffer, then a single pop lets exactly one fetch through
      cycle(1'b0, 1'b1, 32'h0);
      lat_cfg = 0;
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0);
      chk("full_count", buf_count, 3'd4);
      chk("full_no_req", mem_if.mem_req, 1'b0);
      n0 = rise_log.size();
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
      chk("one_refill", rise_log.size() - n0, 1);
      chk("refill_addr", rise_log[rise_log.size()-1], 32'h10);

      // Redirect while a slow request is outstanding
      lat_cfg = 5;
      for (int i = 0; i < 20 && !(out_v && age == 2); i++) cycle(1'b1, 1'b0, '0);
      chk("drop_setup_req", mem_if.mem_req, 1'b1);
      n0 = rise_log.size();
      cycle(1'b1, 1'b1, 32'h1003);
      for (int i = 0; i < 20 && rise_log.size() == n0; i++) cycle(1'b1, 1'b0, '0);
      chk("drop_next_addr", (rise_log.size() > n0) ? rise_log[n0] : 32'hDEAD, 32'h1000);

      // Redirect coincident with ack and pop, two entries buffered
      lat_cfg = 0;
      cycle(1'b0, 1'b1, 32'h3000);
      for (int i = 0; i < 40 && !(q.size() == 2 && out_v); i++) cycle(1'b0, 1'b0, '0);
      chk("coinc_fill", buf_count, 3'd2);
      n0 = rise_log.size();
      cycle(1'b1, 1'b1, 32'h2000);
      chk("coinc_count", buf_count, 3'd0);
      chk("coinc_valid", ir_valid, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
      chk("coinc_next_addr", (rise_log.size() > n0) ? rise_log[n0] : 32'hDEAD, 32'h2000);

      // Address wrap at the top of the address space
      n0 = rise_log.size();
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);
      chk("wrap_addr0", (rise_log.size() > n0) ? rise_log[n0] : 32'hDEAD, 32'hFFFF_FFFC);
      chk("wrap_addr1", (rise_log.size() > n0 + 1) ? rise_log[n0+1] : 32'hDEAD, 32'h0);

      // Reset in the middle of a request with three entries buffered
      cycle(1'b0, 1'b1, 32'h4000);
      for (int i = 0; i < 40 && q.size() < 3; i++) cycle(1'b0, 1'b0, '0);
      lat_cfg = 50;
      for (int i = 0; i < 10 && !out_v; i++) cycle(1'b0, 1'b0, '0);
      chk("rstmid_count", buf_count, 3'd3);
      chk("rstmid_req", mem_if.mem_req, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("rstmid_req_drop", mem_if.mem_req, 1'b0);
      chk("rstmid_buf_count", buf_count, 3'd0);
      chk("rstmid_fetch_pc", fetch_pc, RST_PC);
      chk("rstmid_ir_valid", ir_valid, 1'b0);
      mem_if.mem_ack = 1'b0;
      ir_ready       = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      lat_cfg = -1;
      n0 = rise_log.size();
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0);
      chk("rstmid_restart", (rise_log.size() > n0) ? rise_log[n0] : 32'hDEAD, RST_PC);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         bit rdy, rd;
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 29) == 0);
         cycle(rdy, rd, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the next-generation MIPS core.
- Replaces the free-running PC register and direct instruction-memory read with:
  - a PC sequencer;
  - a request/acknowledge memory interface (MOV/MOC style, variable latency);
  - an instruction buffer that decouples fetch from decode.
- Branch/jump targets are computed downstream and applied through a single redirect input, which flushes all in-flight fetch state.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- BUF_DEPTH, 4, instruction buffer entries; power of two, ≥2.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request strobe (MOV).
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1.
- mem_ack  in  1  memory operation complete (MOC); mem_data valid this cycle.
- mem_data  in  DATA_W  fetched instruction word.
- redirect  in  1  one-cycle pulse: discard buffered/in-flight fetches and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] forced to 0.
- ir  out  DATA_W  instruction at buffer head.
- ir_pc  out  ADDR_W  address of ir.
- ir_valid  out  1  buffer non-empty.
- ir_ready  in  1  consumer pops head when ir_valid=1 and ir_ready=1.
- fetch_pc  out  ADDR_W  address of next fetch to issue.
- buf_count  out  $clog2(BUF_DEPTH)+1  occupied buffer entries.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, fetch_pc=RESET_PC, mem_addr=RESET_PC, mem_req=0.
  - Buffer pointers and buf_count=0, ir_valid=0, ir=0, ir_pc=0.
- FSM states IDLE, REQ, DROP. At most one outstanding request.
- IDLE:
  - If buf_count<BUF_DEPTH (after this cycle's pop), next cycle enter REQ with mem_req=1, mem_addr=fetch_pc.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req and mem_addr are held until mem_ack; a request is never withdrawn.
  - On mem_ack: push {mem_data, mem_addr} into buffer, fetch_pc += PC_STEP (mod 2^ADDR_W), mem_req=0, return to IDLE.
- Issue rate: one issue per two cycles minimum (REQ→IDLE→REQ). With zero-wait memory (ack in the first REQ cycle), throughput is one instruction per 2 cycles.
- Latency: mem_ack in cycle n → ir_valid=1 in cycle n+1 if the buffer was empty.
- Buffer:
  - Circular FIFO, pointers wrap mod BUF_DEPTH.
  - ir/ir_pc are registered head contents.
  - Push and pop in the same cycle are both performed; buf_count is unchanged.
  - A push never occurs when full: issue is gated so that buf_count plus outstanding requests ≤ BUF_DEPTH.
- Redirect (highest priority; any state):
  - Buffer flushed: pointers and buf_count=0, ir_valid=0 next cycle; a concurrent pop is ignored.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In IDLE: go to IDLE; a new request issues the following cycle.
  - In REQ without mem_ack: go to DROP; mem_req stays 1 with the old mem_addr.
  - In REQ with mem_ack in the same cycle: the returned data is discarded; go to IDLE.
  - In DROP: stay in DROP; update fetch_pc only.
- DROP:
  - Hold the old request until mem_ack, then discard data, mem_req=0, go to IDLE.
  - Fetch resumes from fetch_pc.
- Reset asserted mid-request: mem_req drops immediately. Memory must tolerate an abandoned request on reset only.

Test Plan:
- Reset release, mem_ack always 1 the cycle after mem_req rises → mem_addr sequence 0x0,0x4,0x8,…; ir/ir_pc match mem_data/address; first ir_valid 2 cycles after first mem_req.
- ir_ready=0, BUF_DEPTH=4, immediate acks → exactly 4 pushes, buf_count=4, mem_req stays 0. Raise ir_ready one cycle → one pop, exactly one new request at 0x10.
- Redirect to 0x1003 while REQ waits (ack delayed 5 cycles) → DROP held, mem_addr unchanged until ack, that data never appears on ir; next mem_addr=0x1000.
- Redirect coincident with mem_ack and ir_ready with buffer holding 2 entries → buf_count=0, ir_valid=0 next cycle, acked word dropped, next fetch at redirect target.
- PC wrap: RESET_PC=0xFFFFFFFC → second fetch address 0x00000000.
- Reset asserted in REQ with 3 buffered entries → same-cycle mem_req=0, buf_count=0, fetch_pc=RESET_PC; after release, normal fetch from RESET_PC.
